// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator frequency meter: counts synchronised rising edges of osc_in
// over a fixed window of GATE_CYCLES clk cycles and holds the result with a valid flag.
module ring_osc_freq_meter #(
  parameter int GATE_CYCLES = 1024,
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             osc_in,
  input  logic             start,
  output logic             busy,
  output logic             valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int WIN_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [WIN_W-1:0] WIN_INIT = WIN_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   history;
  logic                   rise;
  logic [WIN_W-1:0]       win;
  logic [CNT_W-1:0]       acc;
  logic                   overflow_acc;

  // Synchroniser and history run in every state so a gate never starts on a fake edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= '0;
      history <= 1'b0;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], osc_in};
      history <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~history;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      valid        <= 1'b0;
      count        <= '0;
      overflow     <= 1'b0;
      win          <= '0;
      acc          <= '0;
      overflow_acc <= 1'b0;
    end else if (!ena) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc          <= '0;
            overflow_acc <= 1'b0;
            win          <= WIN_INIT;
            valid        <= 1'b0;
            busy         <= 1'b1;
            state        <= GATE;
          end
        end
        GATE: begin
          if (rise) begin
            if (acc == '1) overflow_acc <= 1'b1;
            else           acc          <= acc + CNT_W'(1);
          end
          if (win == '0) state <= DONE;
          else           win   <= win - WIN_W'(1);
        end
        DONE: begin
          count    <= acc;
          overflow <= overflow_acc;
          valid    <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Bench for ring_osc_freq_meter: a 64-cycle/16-bit instance and a 256-cycle/4-bit
// instance measuring a period-4 oscillator, with a queue of expected results.
module tb_ring_osc_freq_meter;

  localparam int G_M = 64;
  localparam int W_M = 16;
  localparam int G_S = 256;
  localparam int W_S = 4;

  logic clk, rst_n, ena, osc, osc_en;
  logic start_m, start_s;
  logic busy_m, valid_m, overflow_m;
  logic [W_M-1:0] count_m;
  logic busy_s, valid_s, overflow_s;
  logic [W_S-1:0] count_s;

  typedef struct {
    logic [15:0] cnt;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int passed = 0;
  int total  = 0;

  ring_osc_freq_meter #(.GATE_CYCLES(G_M), .CNT_W(W_M), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc), .start(start_m),
    .busy(busy_m), .valid(valid_m), .count(count_m), .overflow(overflow_m)
  );

  ring_osc_freq_meter #(.GATE_CYCLES(G_S), .CNT_W(W_S), .SYNC_STAGES(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .osc_in(osc), .start(start_s),
    .busy(busy_s), .valid(valid_s), .count(count_s), .overflow(overflow_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Period 40 = 4 clk periods; edges sit 2 time units off the clk edges.
  initial begin
    osc = 1'b0;
    #3;
    forever begin
      if (osc_en) begin
        osc = 1'b1; #20;
        osc = 1'b0; #20;
      end else begin
        osc = 1'b0; #10;
      end
    end
  end

  function automatic exp_t model(input int edges, input int cnt_w);
    exp_t e;
    int   max;
    max = (1 << cnt_w) - 1;
    if (edges > max) begin
      e.cnt = 16'(max);
      e.ovf = 1'b1;
    end else begin
      e.cnt = 16'(edges);
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  // Drives one start pulse and waits for valid; edges counts the sampling edge as 1.
  task automatic measure(input bit sat, input int extra_at,
                         output int edges, output int busy_cycles,
                         output logic valid_first, output bit timed_out);
    bit done;
    done = 0;
    busy_cycles = 0;
    valid_first = 1'bx;
    @(negedge clk);
    if (sat) start_s = 1'b1; else start_m = 1'b1;
    @(posedge clk);
    edges = 1;
    for (int i = 1; i <= 2000 && !done; i++) begin
      @(negedge clk);
      if (sat) start_s = (i == extra_at); else start_m = (i == extra_at);
      if (i == 1) valid_first = sat ? valid_s : valid_m;
      if (sat ? valid_s : valid_m) done = 1;
      else begin
        if (sat ? busy_s : busy_m) busy_cycles++;
        @(posedge clk);
        edges++;
      end
    end
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; start_m = 1'b0; start_s = 1'b0; osc_en = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if ({busy_m, valid_m, count_m, overflow_m} !== '0) begin
      $display("FAIL reset_main: got busy=%b valid=%b count=%0d ovf=%b, want all 0",
               busy_m, valid_m, count_m, overflow_m);
    end else passed++;
    total++;
    if ({busy_s, valid_s, count_s, overflow_s} !== '0) begin
      $display("FAIL reset_sat: got busy=%b valid=%b count=%0d ovf=%b, want all 0",
               busy_s, valid_s, count_s, overflow_s);
    end else passed++;
  endtask

  task automatic test_zero_input();
    int edges, bc; logic vf; bit to; exp_t e;
    sb.push_back(model(0, W_M));
    measure(1'b0, 0, edges, bc, vf, to);
    total++;
    if (to || edges != G_M + 2) $display("FAIL zero_latency: got edges=%0d timeout=%0b, want %0d", edges, to, G_M + 2);
    else passed++;
    total++;
    if (bc != G_M + 1) $display("FAIL zero_busy: got %0d busy cycles, want %0d", bc, G_M + 1);
    else passed++;
    e = sb.pop_front();
    total++;
    if (count_m !== e.cnt || overflow_m !== e.ovf)
      $display("FAIL zero_result: got count=%0d ovf=%b, want count=%0d ovf=%b", count_m, overflow_m, e.cnt, e.ovf);
    else passed++;
  endtask

  task automatic test_period4();
    int edges, bc; logic vf; bit to; exp_t e;
    osc_en = 1'b1;
    repeat (7) @(negedge clk);
    sb.push_back(model(G_M / 4, W_M));
    measure(1'b0, 0, edges, bc, vf, to);
    total++;
    if (vf !== 1'b0) $display("FAIL p4_valid_drop: got valid=%b after new start, want 0", vf);
    else passed++;
    total++;
    if (to || edges != G_M + 2) $display("FAIL p4_latency: got edges=%0d timeout=%0b, want %0d", edges, to, G_M + 2);
    else passed++;
    e = sb.pop_front();
    total++;
    if (count_m !== e.cnt || overflow_m !== e.ovf)
      $display("FAIL p4_result: got count=%0d ovf=%b, want count=%0d ovf=%b", count_m, overflow_m, e.cnt, e.ovf);
    else passed++;
  endtask

  task automatic test_saturate();
    int edges, bc; logic vf; bit to; exp_t e;
    sb.push_back(model(G_S / 4, W_S));
    measure(1'b1, 0, edges, bc, vf, to);
    total++;
    if (to || edges != G_S + 2) $display("FAIL sat_latency: got edges=%0d timeout=%0b, want %0d", edges, to, G_S + 2);
    else passed++;
    e = sb.pop_front();
    total++;
    if ({12'd0, count_s} !== e.cnt || overflow_s !== e.ovf)
      $display("FAIL sat_result: got count=%0d ovf=%b, want count=%0d ovf=%b", count_s, overflow_s, e.cnt, e.ovf);
    else passed++;
  endtask

  task automatic test_start_while_busy();
    int edges, bc; logic vf; bit to; exp_t e;
    sb.push_back(model(G_M / 4, W_M));
    measure(1'b0, 10, edges, bc, vf, to);
    total++;
    if (to || edges != G_M + 2) $display("FAIL busy_start_latency: got edges=%0d timeout=%0b, want %0d", edges, to, G_M + 2);
    else passed++;
    e = sb.pop_front();
    total++;
    if (count_m !== e.cnt || overflow_m !== e.ovf)
      $display("FAIL busy_start_result: got count=%0d ovf=%b, want count=%0d ovf=%b", count_m, overflow_m, e.cnt, e.ovf);
    else passed++;
    repeat (5) @(negedge clk);
    total++;
    if (busy_m !== 1'b0 || valid_m !== 1'b1)
      $display("FAIL busy_start_no_queue: got busy=%b valid=%b, want busy=0 valid=1", busy_m, valid_m);
    else passed++;
  endtask

  task automatic test_ena_abort();
    bit rose;
    // With ena low in IDLE the old result stays and start is ignored.
    @(negedge clk);
    ena = 1'b0; start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (busy_m !== 1'b0 || valid_m !== 1'b1 || count_m !== 16'd16)
      $display("FAIL ena_idle: got busy=%b valid=%b count=%0d, want busy=0 valid=1 count=16", busy_m, valid_m, count_m);
    else passed++;
    ena = 1'b1;
    @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    repeat (19) @(negedge clk);
    total++;
    if (busy_m !== 1'b1) $display("FAIL ena_pre_abort: got busy=%b, want 1", busy_m);
    else passed++;
    ena = 1'b0;
    @(negedge clk);
    // valid was already cleared when this run was started.
    total++;
    if (busy_m !== 1'b0 || valid_m !== 1'b0 || count_m !== 16'd16 || overflow_m !== 1'b0)
      $display("FAIL ena_abort: got busy=%b valid=%b count=%0d ovf=%b, want busy=0 valid=0 count=16 ovf=0",
               busy_m, valid_m, count_m, overflow_m);
    else passed++;
    ena = 1'b1;
    rose = 0;
    repeat (G_M + 10) begin
      @(negedge clk);
      if (valid_m || busy_m) rose = 1;
    end
    total++;
    if (rose) $display("FAIL ena_no_valid: got busy/valid activity=1 after abort, want 0");
    else passed++;
  endtask

  task automatic test_async_reset();
    int edges, bc; logic vf; bit to; exp_t e;
    @(negedge clk);
    start_m = 1'b1;
    @(negedge clk);
    start_m = 1'b0;
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy_m, valid_m, count_m, overflow_m} !== '0)
      $display("FAIL async_reset: got busy=%b valid=%b count=%0d ovf=%b, want all 0",
               busy_m, valid_m, count_m, overflow_m);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    sb.push_back(model(G_M / 4, W_M));
    measure(1'b0, 0, edges, bc, vf, to);
    total++;
    if (to || edges != G_M + 2) $display("FAIL post_reset_latency: got edges=%0d timeout=%0b, want %0d", edges, to, G_M + 2);
    else passed++;
    e = sb.pop_front();
    total++;
    if (count_m !== e.cnt || overflow_m !== e.ovf)
      $display("FAIL post_reset_result: got count=%0d ovf=%b, want count=%0d ovf=%b", count_m, overflow_m, e.cnt, e.ovf);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_input();
    test_period4();
    test_saturate();
    test_start_while_busy();
    test_ena_abort();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
